// File: rtl/twod_ncl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : twod_ncl_pkg
// Brief   : Dual-rail (NCL) encodings and phase type shared by the counter ring.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package twod_ncl_pkg;

   typedef logic [1:0] dr_t;

   localparam dr_t DR_NULL  = 2'b00;
   localparam dr_t DR_FALSE = 2'b01;
   localparam dr_t DR_TRUE  = 2'b10;

   typedef enum logic [0:0] {
      WAIT_DATA = 1'b0,
      WAIT_NULL = 1'b1
   } phase_e;

   function automatic dr_t dr_encode(input logic b);
      return b ? DR_TRUE : DR_FALSE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ncl_th12.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : ncl_th12
// Brief   : 2-input threshold-1 gate: flags a dual-rail pair as complete (any rail high).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module ncl_th12
   import twod_ncl_pkg::*;
(
   input  logic [1:0] rail_i,
   output logic       complete_o
);

   assign complete_o = rail_i[1] | rail_i[0];

endmodule
`default_nettype wire

// File: rtl/twod_counter_ring_b.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : twod_counter_ring_b
// Brief   : One dual-rail counter digit with four-phase handshake; digits chain
//           carry_out/carry_ack -> carry_in/ack_out into an N-digit ripple counter.
//           Optional TWOD_ILLEGAL_CHECK_EN adds a sticky err output for carry_in=11.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module twod_counter_ring_b
   import twod_ncl_pkg::*;
#(
   parameter logic INIT_STATE = 1'b0
) (
   input  logic       clk,
   input  logic       init,
   input  logic [1:0] carry_in,
   input  logic       sum_ack,
   input  logic       carry_ack,
   output logic [1:0] sum,
   output logic [1:0] carry_out,
   output logic       ack_out
`ifdef TWOD_ILLEGAL_CHECK_EN
   ,
   output logic       err
`endif
);

   phase_e phase_q, phase_d;
   logic   cnt_q,   cnt_d;
   dr_t    sum_q,   sum_d;
   dr_t    carry_q, carry_d;

   logic   w_ci_complete;
   logic   w_ci_illegal;
   logic   w_ci_data;
   logic   w_ci_null;
   logic   w_inc;
   logic   w_fire_data;
   logic   w_fire_null;

   ncl_th12 u_ci_th12 (
      .rail_i     (carry_in),
      .complete_o (w_ci_complete)
   );

   assign w_ci_illegal = carry_in[1] & carry_in[0];
   assign w_ci_data    = w_ci_complete & ~w_ci_illegal;
   assign w_ci_null    = ~w_ci_complete;
   assign w_inc        = carry_in[1];

   // A wavefront only advances once both consumers agree on the opposite phase.
   assign w_fire_data  = (phase_q == WAIT_DATA) & w_ci_data & ~sum_ack & ~carry_ack;
   assign w_fire_null  = (phase_q == WAIT_NULL) & w_ci_null &  sum_ack &  carry_ack;

   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      if (w_fire_data) begin
         sum_d   = dr_encode(cnt_q ^ w_inc);
         carry_d = dr_encode(cnt_q & w_inc);
         cnt_d   = cnt_q ^ w_inc;
         phase_d = WAIT_NULL;
      end else if (w_fire_null) begin
         sum_d   = DR_NULL;
         carry_d = DR_NULL;
         phase_d = WAIT_DATA;
      end
   end

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         phase_q <= WAIT_DATA;
         cnt_q   <= INIT_STATE;
         sum_q   <= DR_NULL;
         carry_q <= DR_NULL;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign sum       = sum_q;
   assign carry_out = carry_q;
   assign ack_out   = (phase_q == WAIT_NULL);

`ifdef TWOD_ILLEGAL_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         err_q <= 1'b0;
      end else if (w_ci_illegal) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

`ifndef SYNTHESIS
   a_never_11: assert property (@(posedge clk) disable iff (init)
      !(&sum_q) && !(&carry_q));
   a_rails_together: assert property (@(posedge clk) disable iff (init)
      ((sum_q == DR_NULL) == (carry_q == DR_NULL)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_twod_counter_ring_b.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_twod_counter_ring_b
// Brief   : Directed self-checking bench: single digit handshake cases plus a
//           4-digit ripple chain counting 1..15,0.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_twod_counter_ring_b;
   import twod_ncl_pkg::*;

   logic       clk;
   logic       init;
   logic [1:0] carry_in;
   logic       sum_ack;
   logic       carry_ack;
   logic [1:0] sum;
   logic [1:0] carry_out;
   logic       ack_out;
`ifdef TWOD_ILLEGAL_CHECK_EN
   logic       err;
   logic       ch_err [4];
`endif

   int n_checks = 0;
   int n_fail   = 0;

   twod_counter_ring_b #(.INIT_STATE(1'b0)) dut (
      .clk       (clk),
      .init      (init),
      .carry_in  (carry_in),
      .sum_ack   (sum_ack),
      .carry_ack (carry_ack),
      .sum       (sum),
      .carry_out (carry_out),
      .ack_out   (ack_out)
`ifdef TWOD_ILLEGAL_CHECK_EN
      ,
      .err       (err)
`endif
   );

   // 4-digit ripple chain with self-driven digit 0 and auto-acking sinks
   logic [1:0] ch_ci  [4];
   logic [1:0] ch_sum [4];
   logic [1:0] ch_co  [4];
   logic       ch_ack [4];
   logic       ch_cack[4];

   for (genvar i = 0; i < 4; i++) begin : g_chain
      if (i == 0) begin : g_first
         assign ch_ci[i] = {~ch_ack[0], 1'b0};
      end else begin : g_rest
         assign ch_ci[i] = ch_co[i-1];
      end
      if (i == 3) begin : g_sink
         assign ch_cack[i] = |ch_co[3];
      end else begin : g_link
         assign ch_cack[i] = ch_ack[i+1];
      end
      twod_counter_ring_b #(.INIT_STATE(1'b0)) u_digit (
         .clk       (clk),
         .init      (init),
         .carry_in  (ch_ci[i]),
         .sum_ack   (|ch_sum[i]),
         .carry_ack (ch_cack[i]),
         .sum       (ch_sum[i]),
         .carry_out (ch_co[i]),
         .ack_out   (ch_ack[i])
`ifdef TWOD_ILLEGAL_CHECK_EN
         ,
         .err       (ch_err[i])
`endif
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [1:0] s, input logic [1:0] c, input logic a);
      check_val({tag, "_sum"},   {6'd0, sum},       {6'd0, s});
      check_val({tag, "_carry"}, {6'd0, carry_out}, {6'd0, c});
      check_val({tag, "_ack"},   {7'd0, ack_out},   {7'd0, a});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] ci, input logic sa, input logic ca);
      carry_in  = ci;
      sum_ack   = sa;
      carry_ack = ca;
   endtask

   // Chain monitor: record each digit's value at the moment it captures DATA
   logic       mon_en;
   logic       prev_ack [4];
   logic [3:0] vals [0:31];
   logic       co3  [0:31];
   int         cnt  [4];

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mon_en && ch_ack[i] && !prev_ack[i] && cnt[i] < 32) begin
            vals[cnt[i]][i] = (ch_sum[i] == DR_TRUE);
            if (i == 3) co3[cnt[i]] = (ch_co[3] == DR_TRUE);
            cnt[i] = cnt[i] + 1;
         end
         prev_ack[i] = ch_ack[i];
      end
   end

   initial begin
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cnt[i]      = 0;
         prev_ack[i] = 1'b0;
      end
      init = 1'b0;
      drive(2'b00, 1'b0, 1'b0);

      // asynchronous reset, observed before any clock edge
      #2;
      init = 1'b1;
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      check_out("rst_async", DR_NULL, DR_NULL, 1'b0);
      repeat (2) begin
         tick();
         drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check_out("rst_hold", DR_NULL, DR_NULL, 1'b0);
      end
`ifdef TWOD_ILLEGAL_CHECK_EN
      check_val("rst_err", {7'd0, err}, 8'd0);
`endif
      tick();
      init = 1'b0;

      // CNT 0 + inc -> 1, no carry
      drive(2'b10, 1'b0, 1'b0);
      tick();
      check_out("inc1", DR_TRUE, DR_FALSE, 1'b1);
      tick();
      check_out("inc1_hold", DR_TRUE, DR_FALSE, 1'b1);
      drive(2'b00, 1'b1, 1'b1);
      tick();
      check_out("null1", DR_NULL, DR_NULL, 1'b0);

      // CNT 1 + inc -> wrap with carry
      drive(2'b10, 1'b0, 1'b0);
      tick();
      check_out("wrap", DR_FALSE, DR_TRUE, 1'b1);
      drive(2'b00, 1'b1, 1'b1);
      tick();
      check_out("null2", DR_NULL, DR_NULL, 1'b0);

      // CNT 0 + inc -> 1
      drive(2'b10, 1'b0, 1'b0);
      tick();
      check_out("inc3", DR_TRUE, DR_FALSE, 1'b1);
      drive(2'b00, 1'b1, 1'b1);
      tick();

      // no-increment token with CNT=1 leaves CNT at 1
      drive(2'b01, 1'b0, 1'b0);
      tick();
      check_out("noinc", DR_TRUE, DR_FALSE, 1'b1);
      drive(2'b00, 1'b1, 1'b1);
      tick();
      check_out("null4", DR_NULL, DR_NULL, 1'b0);

      // partial ack stalls the wavefront
      drive(2'b10, 1'b1, 1'b0);
      repeat (5) begin
         tick();
         check_out("partial", DR_NULL, DR_NULL, 1'b0);
      end
      sum_ack = 1'b0;
      tick();
      check_out("partial_rel", DR_FALSE, DR_TRUE, 1'b1);

      // illegal carry_in in WAIT_NULL holds
      drive(2'b11, 1'b1, 1'b1);
      tick();
      check_out("ill_null", DR_FALSE, DR_TRUE, 1'b1);
      drive(2'b00, 1'b1, 1'b1);
      tick();
      check_out("null5", DR_NULL, DR_NULL, 1'b0);

      // illegal carry_in in WAIT_DATA holds
      drive(2'b11, 1'b0, 1'b0);
      tick();
      check_out("ill_data", DR_NULL, DR_NULL, 1'b0);
`ifdef TWOD_ILLEGAL_CHECK_EN
      check_val("err_set", {7'd0, err}, 8'd1);
`endif

      // CNT is 0 here; increment then reset mid-wavefront
      drive(2'b10, 1'b0, 1'b0);
      tick();
      check_out("pre_abort", DR_TRUE, DR_FALSE, 1'b1);
`ifdef TWOD_ILLEGAL_CHECK_EN
      check_val("err_sticky", {7'd0, err}, 8'd1);
`endif
      #2;
      init = 1'b1;
      #1;
      check_out("abort", DR_NULL, DR_NULL, 1'b0);
`ifdef TWOD_ILLEGAL_CHECK_EN
      check_val("err_clr", {7'd0, err}, 8'd0);
`endif
      tick();
      init = 1'b0;
      drive(2'b10, 1'b0, 1'b0);
      tick();
      check_out("post_abort", DR_TRUE, DR_FALSE, 1'b1);

      // 4-digit chain from a fresh reset
      init = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         cnt[i]      = 0;
         prev_ack[i] = 1'b0;
      end
      mon_en = 1'b1;
      init   = 1'b0;
      begin
         int cyc;
         cyc = 0;
         while (cnt[3] < 16 && cyc < 3000) begin
            tick();
            cyc++;
         end
         if (cnt[3] < 16) begin
            check_val("chain_timeout", 8'(cnt[3]), 8'd16);
         end else begin
            for (int k = 0; k < 16; k++) begin
               check_val($sformatf("chain_val%0d", k), {4'd0, vals[k]}, 8'((k + 1) % 16));
               check_val($sformatf("chain_co%0d", k), {7'd0, co3[k]}, (k == 15) ? 8'd1 : 8'd0);
            end
         end
      end
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
